// File: rtl/pipelined_loading_machine.sv
// ============================================================================
// Module  : pipelined_loading_machine
// Brief   : Streams DEPTH words from a valid/ready source into consecutive
//           memory word indices starting at BASE_INDEX through one registered
//           write stage. Optional running checksum: LOADER_CHECKSUM_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_loading_machine #(
    parameter int unsigned DEPTH      = 16,
    parameter logic [29:0] BASE_INDEX = 30'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        mem_wen,
    output logic [29:0] mem_index,
    output logic [31:0] mem_wdata,
    output logic [15:0] count,
    output logic        done,
    output logic [31:0] checksum
);

    localparam logic [15:0] c_depth    = DEPTH[15:0];
    localparam logic [15:0] c_depth_m1 = c_depth - 16'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_accepted;
    logic [29:0] r_acc_index;
    logic        r_wen;
    logic [29:0] r_index;
    logic [31:0] r_wdata;
    logic [15:0] r_count;
    logic        r_done;

    logic w_accept;
    logic w_restart;
    logic w_ready;

    // Ready is derived from registered state only, so it never depends on in_valid.
    assign w_ready   = (r_state == ST_LOAD) && (r_accepted < c_depth);
    assign w_accept  = in_valid && w_ready;
    assign w_restart = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_accepted  <= 16'd0;
            r_acc_index <= BASE_INDEX;
            r_wen       <= 1'b0;
            r_index     <= BASE_INDEX;
            r_wdata     <= 32'd0;
            r_count     <= 16'd0;
            r_done      <= 1'b0;
        end else begin
            r_wen <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_restart) begin
                        r_state     <= ST_LOAD;
                        r_accepted  <= 16'd0;
                        r_acc_index <= BASE_INDEX;
                        r_count     <= 16'd0;
                        r_done      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_wen       <= 1'b1;
                        r_index     <= r_acc_index;
                        r_wdata     <= in_data;
                        r_acc_index <= r_acc_index + 30'd1;
                        r_accepted  <= r_accepted + 16'd1;
                    end
                    if (r_wen) begin
                        r_count <= r_count + 16'd1;
                        if (r_count == c_depth_m1) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    // Carry out of bit 31 is discarded to match the adding machine's accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_checksum <= 32'd0;
        end else if (w_restart) begin
            r_checksum <= 32'd0;
        end else if (r_wen) begin
            r_checksum <= r_checksum + r_wdata;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 32'd0;
`endif

    assign in_ready  = w_ready;
    assign mem_wen   = r_wen;
    assign mem_index = r_index;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_loading_machine.sv
// ============================================================================
// Module  : tb_pipelined_loading_machine
// Brief   : Table-driven directed bench for pipelined_loading_machine, with
//           hand sequences for index wrap and asynchronous mid-burst reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_loading_machine;

    logic        clk;
    logic        reset;

    logic        start_a, valid_a, ready_a, wen_a, done_a;
    logic [31:0] data_a, wdata_a, cs_a;
    logic [29:0] index_a;
    logic [15:0] count_a;

    logic        start_b, valid_b, ready_b, wen_b, done_b;
    logic [31:0] data_b, wdata_b, cs_b;
    logic [29:0] index_b;
    logic [15:0] count_b;

    int n_cmp;
    int n_err;

    pipelined_loading_machine #(.DEPTH(4), .BASE_INDEX(30'd8)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in_valid(valid_a),
        .in_ready(ready_a), .in_data(data_a), .mem_wen(wen_a),
        .mem_index(index_a), .mem_wdata(wdata_a), .count(count_a),
        .done(done_a), .checksum(cs_a)
    );

    pipelined_loading_machine #(.DEPTH(4), .BASE_INDEX(30'h3FFFFFFE)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(valid_b),
        .in_ready(ready_b), .in_data(data_b), .mem_wen(wen_b),
        .mem_index(index_b), .mem_wdata(wdata_b), .count(count_b),
        .done(done_b), .checksum(cs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        valid;
        logic [31:0] data;
        logic        rdy;
        logic        wen;
        logic [29:0] idx;
        logic [31:0] wd;
        logic [15:0] cnt;
        logic        done;
        logic [31:0] cs;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [31:0] cs_exp(input logic [31:0] v);
`ifdef LOADER_CHECKSUM_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [29:0] exp_idx [4];
    bit          seen;

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        start_a = 0; valid_a = 0; data_a = 0;
        start_b = 0; valid_b = 0; data_b = 0;

        //          st vl data    rdy wen idx    wd   cnt done cs
        vecs[0]  = '{0, 0, 32'd0,  0,  0,  30'd8, 32'd0,  16'd0, 0, 32'd0};
        vecs[1]  = '{1, 0, 32'd0,  0,  0,  30'd8, 32'd0,  16'd0, 0, 32'd0};
        vecs[2]  = '{0, 1, 32'd1,  1,  0,  30'd8, 32'd0,  16'd0, 0, 32'd0};
        vecs[3]  = '{0, 1, 32'd2,  1,  1,  30'd8, 32'd1,  16'd0, 0, 32'd0};
        vecs[4]  = '{0, 1, 32'd3,  1,  1,  30'd9, 32'd2,  16'd1, 0, 32'd1};
        vecs[5]  = '{0, 1, 32'd4,  1,  1,  30'd10, 32'd3, 16'd2, 0, 32'd3};
        vecs[6]  = '{0, 1, 32'd5,  0,  1,  30'd11, 32'd4, 16'd3, 0, 32'd6};
        vecs[7]  = '{0, 0, 32'd0,  0,  0,  30'd11, 32'd4, 16'd4, 1, 32'd10};
        vecs[8]  = '{0, 0, 32'd0,  0,  0,  30'd11, 32'd4, 16'd4, 1, 32'd10};
        vecs[9]  = '{1, 0, 32'd0,  0,  0,  30'd11, 32'd4, 16'd4, 1, 32'd10};
        vecs[10] = '{0, 1, 32'd10, 1,  0,  30'd11, 32'd4, 16'd0, 0, 32'd0};
        vecs[11] = '{0, 0, 32'd0,  1,  1,  30'd8, 32'd10, 16'd0, 0, 32'd0};
        vecs[12] = '{1, 1, 32'd20, 1,  0,  30'd8, 32'd10, 16'd1, 0, 32'd10};
        vecs[13] = '{0, 0, 32'd0,  1,  1,  30'd9, 32'd20, 16'd1, 0, 32'd10};
        vecs[14] = '{0, 1, 32'd30, 1,  0,  30'd9, 32'd20, 16'd2, 0, 32'd30};
        vecs[15] = '{0, 0, 32'd0,  1,  1,  30'd10, 32'd30, 16'd2, 0, 32'd30};
        vecs[16] = '{0, 1, 32'd40, 1,  0,  30'd10, 32'd30, 16'd3, 0, 32'd60};
        vecs[17] = '{0, 0, 32'd0,  0,  1,  30'd11, 32'd40, 16'd3, 0, 32'd60};
        vecs[18] = '{0, 0, 32'd0,  0,  0,  30'd11, 32'd40, 16'd4, 1, 32'd100};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_wen", {31'd0, wen_a}, 32'd0);
        chk("reset_idx", {2'b00, index_a}, 32'd8);
        reset = 1'b1;
        tick();

        // Stream cases: back-to-back burst, restart from DONE, gapped valid, start in LOAD.
        for (int i = 0; i < 19; i++) begin
            start_a = vecs[i].start;
            valid_a = vecs[i].valid;
            data_a  = vecs[i].data;
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, ready_a}, {31'd0, vecs[i].rdy});
            chk($sformatf("v%0d_wen", i),   {31'd0, wen_a},   {31'd0, vecs[i].wen});
            chk($sformatf("v%0d_index", i), {2'b00, index_a}, {2'b00, vecs[i].idx});
            chk($sformatf("v%0d_wdata", i), wdata_a, vecs[i].wd);
            chk($sformatf("v%0d_count", i), {16'd0, count_a}, {16'd0, vecs[i].cnt});
            chk($sformatf("v%0d_done", i),  {31'd0, done_a},  {31'd0, vecs[i].done});
            chk($sformatf("v%0d_csum", i),  cs_a, cs_exp(vecs[i].cs));
            tick();
        end
        start_a = 0; valid_a = 0;

        // Index wrap on instance B.
        exp_idx[0] = 30'h3FFFFFFE;
        exp_idx[1] = 30'h3FFFFFFF;
        exp_idx[2] = 30'h00000000;
        exp_idx[3] = 30'h00000001;
        start_b = 1;
        tick();
        start_b = 0;
        valid_b = 1;
        data_b  = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("wrap%0d_wen", k), {31'd0, wen_b}, 32'd1);
            chk($sformatf("wrap%0d_index", k), {2'b00, index_b}, {2'b00, exp_idx[k]});
        end
        valid_b = 0;
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            if (done_b) seen = 1;
            else tick();
        end
        chk("wrap_done_seen", {31'd0, seen}, 32'd1);
        chk("wrap_count", {16'd0, count_b}, 32'd4);
        chk("wrap_csum", cs_b, cs_exp(32'hFFFFFFFC));

        // Asynchronous reset between the 2nd accept and its write on instance A.
        start_a = 1;
        tick();
        start_a = 0;
        valid_a = 1;
        data_a  = 32'h11;
        tick();
        data_a  = 32'h22;
        tick();
        valid_a = 0;
        chk("prerst_wen", {31'd0, wen_a}, 32'd1);
        chk("prerst_count", {16'd0, count_a}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_wen", {31'd0, wen_a}, 32'd0);
        chk("rst_count", {16'd0, count_a}, 32'd0);
        chk("rst_index", {2'b00, index_a}, 32'd8);
        chk("rst_ready", {31'd0, ready_a}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_done", {31'd0, done_a}, 32'd0);
        start_a = 1;
        tick();
        start_a = 0;
        valid_a = 1;
        data_a  = 32'h33;
        tick();
        valid_a = 0;
        chk("restart_wen", {31'd0, wen_a}, 32'd1);
        chk("restart_index", {2'b00, index_a}, 32'd8);
        chk("restart_wdata", wdata_a, 32'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
